// File: rtl/wb_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module   : wb_gpio_bank
//  Purpose  : Wishbone-slave GPIO bank with one set of output, output-enable,
//             input, interrupt-enable, interrupt-polarity and interrupt-status
//             registers. Each register is split into a low word (pins 31:0)
//             and a high word (pins 63:32). Each pin has an edge interrupt.
//             Pins in RSVD_MASK are never driven and never raise an interrupt.
//  Ports    : wb_clk_i / nrst        - clock, synchronous active-low reset
//             wbs_*                  - classic Wishbone slave, single-cycle ack
//             gpio_in                - asynchronous pad inputs
//             gpio_out / gpio_oeb    - pad outputs, active-low output enable
//             irq_o                  - registered level interrupt
//  Options  : GPIO_DEBOUNCE_EN - adds a per-pin 16-sample stable filter after
//             the synchroniser, and a DEBOUNCE_BYP register at 0x30/0x34.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_gpio_bank #(
    parameter int          NUM_GPIO    = 38,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [63:0] RSVD_MASK   = 64'h1E,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                wb_clk_i,
    input  logic                nrst,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq_o
);

    // Registers are kept 64 bits wide so that both words decode uniformly.
    // Bits at or above NUM_GPIO are masked on write and therefore stay 0.
    localparam logic [63:0] c_VALID   = {64{1'b1}} >> (64 - NUM_GPIO);
    localparam logic [63:0] c_RSVD    = RSVD_MASK & c_VALID;
    localparam logic [63:0] c_PINMASK = c_VALID & ~c_RSVD;

    localparam logic [4:0] c_IDX_OUT  = 5'd0;
    localparam logic [4:0] c_IDX_OEB  = 5'd1;
    localparam logic [4:0] c_IDX_IN   = 5'd2;
    localparam logic [4:0] c_IDX_EN   = 5'd3;
    localparam logic [4:0] c_IDX_POL  = 5'd4;
    localparam logic [4:0] c_IDX_STAT = 5'd5;
`ifdef GPIO_DEBOUNCE_EN
    localparam logic [4:0] c_IDX_DEB  = 5'd6;
`endif

    logic [63:0] r_out;
    logic [63:0] r_oeb;
    logic [63:0] r_en;
    logic [63:0] r_pol;
    logic [63:0] r_stat;
    logic [63:0] r_prev;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_irq;

    logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] r_sync;

    logic                w_hit;
    logic                w_wr;
    logic [4:0]          w_idx;
    logic                w_word;
    logic [31:0]         w_lane;
    logic [63:0]         w_bmask;
    logic [63:0]         w_wbits;
    logic [63:0]         w_w1c;
    logic [NUM_GPIO-1:0] w_sync;
    logic [NUM_GPIO-1:0] w_filt;
    logic [63:0]         w_in64;
    logic [63:0]         w_set;
    logic [63:0]         w_rd64;
    logic [31:0]         w_rd32;
    logic                w_unused;

    // Byte address bits 1:0 carry no information for word registers.
    assign w_unused = ^wbs_adr_i[1:0];

    // ------------------------------------------------------------------
    // Bus decode. Gating with the current ack forces one idle cycle
    // between transfers, so a held strobe is not acknowledged twice.
    // ------------------------------------------------------------------
    assign w_hit  = wbs_cyc_i & wbs_stb_i & ~r_ack &
                    (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr   = w_hit & wbs_we_i;
    assign w_idx  = wbs_adr_i[7:3];
    assign w_word = wbs_adr_i[2];

    assign w_lane  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_bmask = w_word ? {w_lane, 32'h0} : {32'h0, w_lane};
    assign w_wbits = {wbs_dat_i, wbs_dat_i} & w_bmask & c_VALID;
    assign w_w1c   = (w_wr && (w_idx == c_IDX_STAT)) ? w_wbits : 64'h0;

    function automatic logic [63:0] f_merge(input logic [63:0] cur,
                                            input logic [63:0] mask,
                                            input logic [63:0] bits);
        return (cur & ~mask) | bits;
    endfunction

    // ------------------------------------------------------------------
    // Input path: synchroniser, optional debounce, then the edge detector.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!nrst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [63:0] r_deb;

    always_ff @(posedge wb_clk_i) begin
        if (!nrst) begin
            r_deb <= 64'h0;
        end else if (w_wr && (w_idx == c_IDX_DEB)) begin
            r_deb <= f_merge(r_deb, w_bmask, w_wbits);
        end
    end

    // The counter runs only while the synchronised input disagrees with
    // the filtered value; the 16th consecutive disagreeing sample commits.
    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_deb
        logic [3:0] r_cnt;
        logic       r_filt;

        always_ff @(posedge wb_clk_i) begin
            if (!nrst) begin
                r_cnt  <= 4'd0;
                r_filt <= 1'b0;
            end else if (w_sync[i] == r_filt) begin
                r_cnt  <= 4'd0;
            end else if (r_cnt == 4'd15) begin
                r_cnt  <= 4'd0;
                r_filt <= w_sync[i];
            end else begin
                r_cnt  <= r_cnt + 4'd1;
            end
        end

        assign w_filt[i] = r_deb[i] ? w_sync[i] : r_filt;
    end
`else
    assign w_filt = w_sync;
`endif

    assign w_in64 = 64'(w_filt) & c_PINMASK;

    // Polarity 1 selects rising edges; polarity 0 selects falling edges.
    assign w_set = ((w_in64 & ~r_prev & r_pol) |
                    (~w_in64 & r_prev & ~r_pol)) & c_PINMASK;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rd64 = 64'h0;
        case (w_idx)
            c_IDX_OUT:  w_rd64 = r_out;
            c_IDX_OEB:  w_rd64 = r_oeb;
            c_IDX_IN:   w_rd64 = w_in64;
            c_IDX_EN:   w_rd64 = r_en;
            c_IDX_POL:  w_rd64 = r_pol;
            c_IDX_STAT: w_rd64 = r_stat;
`ifdef GPIO_DEBOUNCE_EN
            c_IDX_DEB:  w_rd64 = r_deb;
`endif
            default:    w_rd64 = 64'h0;
        endcase
    end

    assign w_rd32 = w_word ? w_rd64[63:32] : w_rd64[31:0];

    // ------------------------------------------------------------------
    // Register file, status, interrupt and bus response
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!nrst) begin
            r_out  <= 64'h0;
            r_oeb  <= c_VALID;
            r_en   <= 64'h0;
            r_pol  <= 64'h0;
            r_stat <= 64'h0;
            r_prev <= 64'h0;
            r_ack  <= 1'b0;
            r_dat  <= 32'h0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    c_IDX_OUT: r_out <= f_merge(r_out, w_bmask, w_wbits);
                    c_IDX_OEB: r_oeb <= f_merge(r_oeb, w_bmask, w_wbits);
                    c_IDX_EN:  r_en  <= f_merge(r_en,  w_bmask, w_wbits);
                    c_IDX_POL: r_pol <= f_merge(r_pol, w_bmask, w_wbits);
                    default:   ;
                endcase
            end
            // A new edge wins over a clear that lands in the same cycle.
            r_stat <= (r_stat & ~w_w1c) | w_set;
            r_prev <= w_in64;
            r_irq  <= |(r_stat & r_en);
            r_ack  <= w_hit;
            if (w_hit) begin
                r_dat <= wbs_we_i ? 32'h0 : w_rd32;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;
    assign gpio_out  = r_out[NUM_GPIO-1:0] & ~c_RSVD[NUM_GPIO-1:0];
    assign gpio_oeb  = r_oeb[NUM_GPIO-1:0] |  c_RSVD[NUM_GPIO-1:0];

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_gpio_bank
//  Purpose  : Self-checking bench for wb_gpio_bank. A register-level model is
//             updated once per clock, based on the bus signals the bench
//             drives and on a history of pad samples. Every cycle, the bench
//             compares the model with the DUT outputs. Directed steps follow
//             the register map, and a randomized phase follows them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_bank;

    localparam int          NUM_GPIO    = 38;
    localparam logic [31:0] BASE_ADDR   = 32'h3000_0000;
    localparam logic [63:0] RSVD_MASK   = 64'h1E;
    localparam int          SYNC_STAGES = 2;

    localparam logic [63:0] VALID   = (64'd1 << NUM_GPIO) - 64'd1;
    localparam logic [63:0] PINMASK = VALID & ~RSVD_MASK;

    logic                clk = 1'b0;
    logic                nrst;
    logic                cyc, stb, we;
    logic [3:0]          sel;
    logic [31:0]         adr, dat;
    logic                wbs_ack_o;
    logic [31:0]         wbs_dat_o;
    logic [NUM_GPIO-1:0] pad;
    logic [NUM_GPIO-1:0] gpio_out, gpio_oeb;
    logic                irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_gpio_bank #(
        .NUM_GPIO   (NUM_GPIO),
        .BASE_ADDR  (BASE_ADDR),
        .RSVD_MASK  (RSVD_MASK),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .wb_clk_i (clk),
        .nrst     (nrst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .gpio_in  (pad),
        .gpio_out (gpio_out),
        .gpio_oeb (gpio_oeb),
        .irq_o    (irq_o)
    );

    // ---------------- reference model ----------------
    logic [63:0] m_out, m_oeb, m_en, m_pol, m_stat, m_deb;
    logic        m_ack, m_irq;
    logic [31:0] m_dat;
    logic [63:0] cap[$];   // pad value seen at each clock edge since reset
    bit          skip_dat = 0;

    // Synchronised (masked) pad value as it stood after capture j + SYNC_STAGES
    function automatic logic [63:0] sv(input int j);
        if (j < 0 || j >= cap.size()) return 64'h0;
        return cap[j] & PINMASK;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [63:0] v;
        case (a[7:3])
            5'd0: v = m_out;
            5'd1: v = m_oeb;
            5'd2: v = sv(cap.size() - SYNC_STAGES);
            5'd3: v = m_en;
            5'd4: v = m_pol;
            5'd5: v = m_stat;
`ifdef GPIO_DEBOUNCE_EN
            5'd6: v = m_deb;
`endif
            default: v = 64'h0;
        endcase
        return a[2] ? v[63:32] : v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: update the model at the edge, then compare outputs 1 time unit later.
    task automatic tick();
        logic        hit, irqn;
        logic [31:0] rd, l32;
        logic [63:0] bm, wd, cur, prv, set, w1c;
        int          n;
        hit  = cyc && stb && !m_ack && (adr[31:8] == BASE_ADDR[31:8]);
        irqn = |(m_stat & m_en);
        rd   = model_read(adr);
        l32  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        bm   = adr[2] ? {l32, 32'h0} : {32'h0, l32};
        wd   = {dat, dat} & bm & VALID;
        @(posedge clk);
        if (!nrst) begin
            m_out = 0; m_oeb = VALID; m_en = 0; m_pol = 0; m_stat = 0; m_deb = 0;
            m_ack = 0; m_dat = 0; m_irq = 0;
            cap.delete();
        end else begin
            cap.push_back(64'(pad));
            n   = cap.size();
            cur = sv(n - 1 - SYNC_STAGES);
            prv = sv(n - 2 - SYNC_STAGES);
            set = (cur & ~prv & m_pol) | (~cur & prv & ~m_pol);
            w1c = 0;
            if (hit && we) begin
                case (adr[7:3])
                    5'd0: m_out = (m_out & ~bm) | wd;
                    5'd1: m_oeb = (m_oeb & ~bm) | wd;
                    5'd3: m_en  = (m_en  & ~bm) | wd;
                    5'd4: m_pol = (m_pol & ~bm) | wd;
                    5'd5: w1c   = wd;
`ifdef GPIO_DEBOUNCE_EN
                    5'd6: m_deb = (m_deb & ~bm) | wd;
`endif
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | set;
            m_irq  = irqn;
            m_ack  = hit;
            if (hit) m_dat = we ? 32'h0 : rd;
        end
        #1;
        chk("ack", 64'(wbs_ack_o), 64'(m_ack));
        if (!skip_dat) chk("dat_o", 64'(wbs_dat_o), 64'(m_dat));
        chk("irq", 64'(irq_o), 64'(m_irq));
        chk("gpio_out", 64'(gpio_out), m_out & PINMASK);
        chk("gpio_oeb", 64'(gpio_oeb), (m_oeb | RSVD_MASK) & VALID);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
        cyc = 1; stb = 1; we = 1; adr = BASE_ADDR + 32'(off); sel = s; dat = d;
        tick();
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
        cyc = 1; stb = 1; we = 0; adr = BASE_ADDR + 32'(off); sel = 4'hF;
        tick();
        d = wbs_dat_o;
        cyc = 0; stb = 0;
        tick();
    endtask

    initial begin
        logic [31:0] rd, rd2;
        int          pulses;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; pad = '0;
        m_ack = 0; m_irq = 0; m_dat = 0; m_out = 0; m_oeb = VALID;
        m_en = 0; m_pol = 0; m_stat = 0; m_deb = 0;

        // Reset and read every offset
        nrst = 0;
        repeat (3) tick();
        nrst = 1;
        tick();
        chk("rst_oeb_pins", 64'(gpio_oeb), VALID);
        chk("rst_irq", 64'(irq_o), 64'h0);
        for (int o = 0; o < 16; o++) begin
            wb_read(8'(o * 4), rd);
            if (o == 2) chk("rst_oeb_w0", 64'(rd), 64'hFFFF_FFFF);
            if (o == 3) chk("rst_oeb_w1", 64'(rd), 64'h0000_003F);
        end

        // Byte-lane write and reserved output masking
        wb_write(8'h00, 4'b0011, 32'hA5A5_A5A5);
        wb_write(8'h08, 4'b1111, 32'h0);
        wb_read(8'h00, rd);
        chk("out_bytelane", 64'(rd), 64'h0000_A5A5);
        chk("gpio_out_lo", 64'(gpio_out[15:0]), 64'hA5A1);
        chk("gpio_oeb_rsvd", 64'(gpio_oeb[4:1]), 64'hF);
        wb_write(8'h04, 4'b0000, 32'hFFFF_FFFF);   // sel=0: ack, no update

        // Held strobe: one ack per hit, then a mandatory idle cycle
        cyc = 1; stb = 1; we = 0; adr = BASE_ADDR;
        pulses = 0;
        tick(); pulses += int'(wbs_ack_o);
        tick(); pulses += int'(wbs_ack_o);
        cyc = 0; stb = 0;
        tick();
        chk("ack_pulses", 64'(pulses), 64'd1);
        cyc = 1; stb = 1; adr = 32'h3000_0100;
        repeat (3) tick();
        chk("miss_no_ack", 64'(wbs_ack_o), 64'h0);
        cyc = 0; stb = 0;
        tick();

        // Rising-edge interrupt on pin 7
        wb_write(8'h18, 4'hF, 32'h80);
        wb_write(8'h20, 4'hF, 32'h80);
        pad[7] = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        chk("irq_before", 64'(irq_o), 64'h0);
        tick();
        chk("irq_set", 64'(irq_o), 64'h1);
        wb_write(8'h28, 4'hF, 32'h80);
        chk("irq_cleared", 64'(irq_o), 64'h0);
        // W1C landing on the same edge as a new rising edge
        pad[7] = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        pad[7] = 1'b1;
        repeat (SYNC_STAGES) tick();
        wb_write(8'h28, 4'hF, 32'h80);
        wb_read(8'h28, rd);
        chk("stat_set_wins", 64'(rd[7]), 64'h1);
        wb_write(8'h28, 4'hF, 32'h80);

        // Reserved pin 2 never reads or interrupts
        wb_write(8'h18, 4'hF, 32'h0000_0004);
        wb_write(8'h20, 4'hF, 32'h0000_0004);
        pad[2] = 1'b1;
        repeat (4) tick();
        pad[2] = 1'b0;
        repeat (4) tick();
        pad[2] = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        wb_read(8'h10, rd);
        chk("rsvd_in", 64'(rd[2]), 64'h0);
        wb_read(8'h28, rd);
        chk("rsvd_stat", 64'(rd[2]), 64'h0);
        chk("rsvd_irq", 64'(irq_o), 64'h0);

`ifdef GPIO_DEBOUNCE_EN
        wb_write(8'h30, 4'hF, 32'hFFFF_FFFF);
        wb_write(8'h34, 4'hF, 32'hFFFF_FFFF);
`endif
        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            pad = NUM_GPIO'({$urandom, $urandom});
            case ($urandom_range(0, 3))
                0: tick();
                1: wb_write(8'($urandom_range(0, 15) * 4), 4'($urandom), $urandom);
                2: wb_read(8'($urandom_range(0, 15) * 4), rd);
                default: begin
                    cyc = 1; stb = 1; we = 1'($urandom);
                    adr = BASE_ADDR + 32'h100 + 32'($urandom_range(0, 15) * 4);
                    sel = 4'hF; dat = $urandom;
                    tick();
                    cyc = 0; stb = 0; we = 0;
                end
            endcase
        end

        // Reset in the middle of a transfer drops it
        cyc = 1; stb = 1; we = 0; adr = BASE_ADDR; nrst = 0;
        tick();
        chk("midrst_ack", 64'(wbs_ack_o), 64'h0);
        cyc = 0; stb = 0; nrst = 1; pad = '0;
        tick();
        wb_read(8'h08, rd);
        chk("midrst_oeb", 64'(rd), 64'hFFFF_FFFF);

`ifdef GPIO_DEBOUNCE_EN
        // Filter enabled on every pin after reset
        skip_dat = 1;
        pad[9] = 1'b1;
        repeat (5) tick();
        pad[9] = 1'b0;
        repeat (SYNC_STAGES + 20) tick();
        wb_read(8'h10, rd);
        chk("deb_glitch", 64'(rd[9]), 64'h0);
        pad[9] = 1'b1;
        repeat (SYNC_STAGES + 15) tick();
        wb_read(8'h10, rd);
        wb_read(8'h10, rd2);
        chk("deb_not_yet", 64'(rd[9]), 64'h0);
        chk("deb_stable", 64'(rd2[9]), 64'h1);
        skip_dat = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
